// File: rtl/bicubic_write_bmp_pkg.sv
// Shared definitions for the bicubic output sink: BMP header layout,
// stall generator defaults and the helpers that build header bytes.
package bicubic_write_bmp_pkg;

  // BMP layout: 14-byte file header followed by a 124-byte V5 info header
  localparam int unsigned FILE_HDR_SIZE = 14;
  localparam int unsigned V5_HDR_SIZE   = 124;
  localparam int unsigned BMP_OFFSET    = FILE_HDR_SIZE + V5_HDR_SIZE;
  localparam int unsigned BMP_BPP       = 24;

  // Byte offsets of the header fields that carry non-zero content
  localparam int unsigned HDR_FILE_SIZE   = 2;
  localparam int unsigned HDR_DATA_OFFSET = 10;
  localparam int unsigned HDR_INFO_SIZE   = 14;
  localparam int unsigned HDR_WIDTH       = 18;
  localparam int unsigned HDR_HEIGHT      = 22;
  localparam int unsigned HDR_PLANES      = 26;
  localparam int unsigned HDR_BPP         = 28;
  localparam int unsigned HDR_COMPRESSION = 30;
  localparam int unsigned HDR_IMAGE_SIZE  = 34;

  // Stall generator: Fibonacci LFSR seed and the longest allowed ready-low run
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
  localparam logic [1:0]  STALL_MAX_RUN     = 2'd3;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
  } sink_state_t;

  // Bytes per stored row: 3 bytes per pixel rounded up to a multiple of 4
  function automatic logic [31:0] rowBytes(input logic [31:0] w);
    return (w * 32'd3 + 32'd3) & ~32'd3;
  endfunction

  // Little-endian byte k of a 32-bit value
  function automatic logic [7:0] le32Byte(input logic [31:0] v, input logic [1:0] k);
    case (k)
      2'd0:    return v[7:0];
      2'd1:    return v[15:8];
      2'd2:    return v[23:16];
      default: return v[31:24];
    endcase
  endfunction

  // True when idx falls inside the field that starts at base and spans len bytes
  function automatic logic inField(input logic [31:0] idx, input int unsigned base,
                                   input int unsigned len);
    return (idx >= base) && (idx < base + len);
  endfunction

  // Header byte at position idx for a w x h 24-bpp image with the given pixel offset
  function automatic logic [7:0] hdrByte(input logic [31:0] idx, input logic [31:0] w,
                                         input logic [31:0] h, input logic [31:0] off);
    logic [31:0] imgSize;
    logic [31:0] fileSize;
    logic [7:0]  b;
    imgSize  = rowBytes(w) * h;
    fileSize = off + imgSize;
    b        = 8'h00;
    if (idx == 32'd0)
      b = 8'h42;
    else if (idx == 32'd1)
      b = 8'h4D;
    else if (inField(idx, HDR_FILE_SIZE, 4))
      b = le32Byte(fileSize, 2'(idx - HDR_FILE_SIZE));
    else if (inField(idx, HDR_DATA_OFFSET, 4))
      b = le32Byte(off, 2'(idx - HDR_DATA_OFFSET));
    else if (inField(idx, HDR_INFO_SIZE, 4))
      b = le32Byte(V5_HDR_SIZE, 2'(idx - HDR_INFO_SIZE));
    else if (inField(idx, HDR_WIDTH, 4))
      b = le32Byte(w, 2'(idx - HDR_WIDTH));
    else if (inField(idx, HDR_HEIGHT, 4))
      b = le32Byte(h, 2'(idx - HDR_HEIGHT));
    else if (inField(idx, HDR_PLANES, 2))
      b = le32Byte(32'd1, 2'(idx - HDR_PLANES));
    else if (inField(idx, HDR_BPP, 2))
      b = le32Byte(BMP_BPP, 2'(idx - HDR_BPP));
    else if (inField(idx, HDR_COMPRESSION, 4))
      b = 8'h00;
    else if (inField(idx, HDR_IMAGE_SIZE, 4))
      b = le32Byte(imgSize, 2'(idx - HDR_IMAGE_SIZE));
    return b;
  endfunction

endpackage

// File: rtl/bicubic_write_bmp_if.sv
// 24-bit valid/ready pixel stream between the upscaler and the BMP sink.
interface bicubic_write_bmp_if;
  logic        valid;
  logic        ready;
  logic [23:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bicubic_write_bmp_stall_gen.sv
// Pseudo-random backpressure source: a 16-bit Fibonacci LFSR decides when the
// sink should drop ready, with a run limiter so a stall never lasts too long.
module bicubic_stall_gen
  import bicubic_write_bmp_pkg::*;
#(
  parameter bit          STALL_EN  = 1'b0,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_ready_next
);

  logic [15:0] r_lfsr;
  logic [1:0]  r_run;
  logic        w_fb;
  logic        w_lfsrReady;

  assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_lfsrReady = (r_lfsr[1:0] != 2'b00) || (r_run == STALL_MAX_RUN);
  assign o_ready_next = STALL_EN ? w_lfsrReady : 1'b1;

  // Step the LFSR every cycle and count consecutive low requests for the limiter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
      r_run  <= 2'd0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
      r_run  <= o_ready_next ? 2'd0 : r_run + 2'd1;
    end
  end

endmodule

// File: rtl/bicubic_write_bmp.sv
// Receiving end of the upscaler pixel stream: accepts one frame, checks the
// handshake protocol, applies optional backpressure and exposes the finished
// 24-bpp BMP image as a byte-addressable read port once the frame completes.
module bicubic_write_bmp
  import bicubic_write_bmp_pkg::*;
#(
  parameter int          DST_WIDTH  = 8,
  parameter int          DST_HEIGHT = 4,
  parameter int          OFFSET     = BMP_OFFSET,
  parameter bit          STALL_EN   = 1'b0,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  bicubic_write_bmp_if.slave  pix_if,
  output logic                o_done,
  output logic [31:0]         o_pix_cnt,
  output logic                o_err_protocol,
  output logic                o_file_valid,
  input  logic [31:0]         i_rd_addr,
  output logic [7:0]          o_rd_byte
);

  localparam int SIZE   = DST_WIDTH * DST_HEIGHT;
  localparam int COL_W  = $clog2(DST_WIDTH > 1 ? DST_WIDTH : 2);
  localparam int ROW_W  = $clog2(DST_HEIGHT > 1 ? DST_HEIGHT : 2);
  localparam int ADDR_W = $clog2(SIZE > 1 ? SIZE : 2);

  localparam logic [31:0]      W_U       = 32'(DST_WIDTH);
  localparam logic [31:0]      H_U       = 32'(DST_HEIGHT);
  localparam logic [31:0]      OFF_U     = 32'(OFFSET);
  localparam logic [31:0]      ROW_BYTES = rowBytes(W_U);
  localparam logic [31:0]      IMG_SIZE  = ROW_BYTES * H_U;
  localparam logic [31:0]      FILE_SIZE = OFF_U + IMG_SIZE;
  localparam logic [31:0]      PIX_BYTES = W_U * 32'd3;
  localparam logic [31:0]      LAST_IDX  = 32'(SIZE - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(DST_WIDTH - 1);

  sink_state_t       r_state;
  logic              r_ready;
  logic              r_done;
  logic              r_fileValid;
  logic [31:0]       r_pixCnt;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [23:0]       r_mem [SIZE];

  logic              r_prevValid;
  logic              r_prevReady;
  logic [23:0]       r_prevData;
  logic              r_err;

  logic              w_readyNext;
  logic              w_hsk;
  logic              w_last;
  logic [ADDR_W-1:0] w_memAddr;

  logic [31:0]       w_off;
  logic [31:0]       w_rowIdx;
  logic [31:0]       w_inRow;
  logic [ADDR_W-1:0] w_pixIdx;
  logic [23:0]       w_pix;

  bicubic_stall_gen #(
    .STALL_EN  (STALL_EN),
    .LFSR_SEED (LFSR_SEED)
  ) u_stall (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_ready_next (w_readyNext)
  );

  assign pix_if.ready   = r_ready;
  assign w_hsk          = pix_if.valid & r_ready;
  assign w_last         = (r_pixCnt == LAST_IDX);
  assign w_memAddr      = ADDR_W'(32'(r_row) * W_U + 32'(r_col));
  assign o_done         = r_done;
  assign o_pix_cnt      = r_pixCnt;
  assign o_err_protocol = r_err;
  assign o_file_valid   = r_fileValid;

  // Frame FSM: raise ready after reset, count accepted pixels, close the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RESET;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_fileValid <= 1'b0;
      r_pixCnt    <= 32'd0;
      r_col       <= '0;
      r_row       <= '0;
    end else begin
      case (r_state)
        ST_RESET: begin
          r_ready <= 1'b1;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_ready <= w_readyNext;
          if (w_hsk) begin
            r_pixCnt <= r_pixCnt + 32'd1;
            if (r_col == COL_LAST) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
            if (w_last) begin
              r_ready     <= 1'b0;
              r_done      <= 1'b1;
              r_fileValid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_ready <= 1'b0;
        end
        default: begin
          r_state <= ST_RESET;
        end
      endcase
    end
  end

  // Pixel store in acceptance order; a reset simply abandons its contents
  always_ff @(posedge clk) begin
    if (w_hsk) begin
      r_mem[w_memAddr] <= pix_if.data;
    end
  end

  // Protocol watch: a stalled transfer must keep valid high and data stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prevValid <= 1'b0;
      r_prevReady <= 1'b0;
      r_prevData  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_prevValid <= pix_if.valid;
      r_prevReady <= r_ready;
      r_prevData  <= pix_if.data;
      if (!r_done && r_prevValid && !r_prevReady &&
          (!pix_if.valid || (pix_if.data != r_prevData))) begin
        r_err <= 1'b1;
      end
    end
  end

  // Image byte view: header, then rows of B,G,R bytes zero-padded to 4 bytes
  always_comb begin
    o_rd_byte = 8'h00;
    w_off     = 32'd0;
    w_rowIdx  = 32'd0;
    w_inRow   = 32'd0;
    w_pixIdx  = '0;
    w_pix     = 24'h0;
    if (r_fileValid) begin
      if (i_rd_addr < OFF_U) begin
        o_rd_byte = hdrByte(i_rd_addr, W_U, H_U, OFF_U);
      end else if (i_rd_addr < FILE_SIZE) begin
        w_off    = i_rd_addr - OFF_U;
        w_rowIdx = w_off / ROW_BYTES;
        w_inRow  = w_off % ROW_BYTES;
        if (w_inRow < PIX_BYTES) begin
          w_pixIdx = ADDR_W'(w_rowIdx * W_U + w_inRow / 32'd3);
          w_pix    = r_mem[w_pixIdx];
          case (w_inRow % 32'd3)
            32'd0:   o_rd_byte = w_pix[7:0];
            32'd1:   o_rd_byte = w_pix[15:8];
            default: o_rd_byte = w_pix[23:16];
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bicubic_write_bmp.sv
// Bench for the BMP sink: one 8x4 instance with ready held high and one 5x4
// instance with LFSR backpressure; accepted pixels are queued and matched
// against the image bytes read back once each frame completes.
module tb_bicubic_write_bmp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  bicubic_write_bmp_if ifA();
  bicubic_write_bmp_if ifB();

  logic        doneA, errA, fileValidA;
  logic [31:0] pixCntA;
  logic [31:0] rdAddrA = 32'd0;
  logic [7:0]  rdByteA;
  logic        doneB, errB, fileValidB;
  logic [31:0] pixCntB;
  logic [31:0] rdAddrB = 32'd0;
  logic [7:0]  rdByteB;

  logic [23:0] qA[$];
  logic [23:0] qB[$];

  bit  monB = 1'b0;
  int  runB = 0;
  int  maxRunB = 0;
  int  stallB = 0;
  time tFirst = 0;
  time tLast = 0;

  bicubic_write_bmp #(
    .DST_WIDTH (8), .DST_HEIGHT (4), .OFFSET (138),
    .STALL_EN (1'b0), .LFSR_SEED (16'hACE1)
  ) dutA (
    .clk (clk), .rst_n (rst_n), .pix_if (ifA),
    .o_done (doneA), .o_pix_cnt (pixCntA), .o_err_protocol (errA),
    .o_file_valid (fileValidA), .i_rd_addr (rdAddrA), .o_rd_byte (rdByteA)
  );

  bicubic_write_bmp #(
    .DST_WIDTH (5), .DST_HEIGHT (4), .OFFSET (138),
    .STALL_EN (1'b1), .LFSR_SEED (16'hACE1)
  ) dutB (
    .clk (clk), .rst_n (rst_n), .pix_if (ifB),
    .o_done (doneB), .o_pix_cnt (pixCntB), .o_err_protocol (errB),
    .o_file_valid (fileValidB), .i_rd_addr (rdAddrB), .o_rd_byte (rdByteB)
  );

  always #5 clk = ~clk;

  // Track the longest ready-low run of the stalling instance during its frame
  always @(negedge clk) begin
    if (monB) begin
      if (!ifB.ready && !doneB) begin
        runB++;
        stallB++;
      end else begin
        runB = 0;
      end
      if (runB > maxRunB) maxRunB = runB;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one pixel and hold it until accepted; the accepted pixel is queued
  task automatic applyStimulus(input int inst, input logic [23:0] d);
    bit got;
    bit rdy;
    int waited;
    got = 1'b0;
    waited = 0;
    if (inst == 0) begin
      ifA.valid = 1'b1;
      ifA.data  = d;
    end else begin
      ifB.valid = 1'b1;
      ifB.data  = d;
    end
    while (!got && waited < 40) begin
      @(negedge clk);
      rdy = (inst == 0) ? ifA.ready : ifB.ready;
      @(posedge clk);
      #1;
      got = rdy;
      waited++;
    end
    if (got) begin
      if (inst == 0) qA.push_back(d);
      else qB.push_back(d);
    end else begin
      checkOutput($sformatf("hsk_timeout_%0d", inst), 32'd0, 32'd1);
    end
  endtask

  task automatic readByte(input int inst, input logic [31:0] addr, output logic [7:0] b);
    if (inst == 0) begin
      rdAddrA = addr;
      #1;
      b = rdByteA;
    end else begin
      rdAddrB = addr;
      #1;
      b = rdByteB;
    end
  endtask

  // Compare the whole image against an independent header model and the queue
  task automatic checkFile(input int inst, input int w, input int h, input string tag);
    logic [31:0] rowB;
    logic [31:0] imgB;
    logic [31:0] fileB;
    logic [7:0]  hdr [138];
    logic [7:0]  b;
    logic [23:0] px;
    int          base;
    rowB  = 32'(((w * 3 + 3) / 4) * 4);
    imgB  = rowB * 32'(h);
    fileB = 32'd138 + imgB;
    for (int i = 0; i < 138; i++) hdr[i] = 8'h00;
    hdr[0] = 8'h42;
    hdr[1] = 8'h4D;
    for (int k = 0; k < 4; k++) begin
      hdr[2 + k]  = fileB[8*k +: 8];
      hdr[10 + k] = 8'(138 >> (8 * k));
      hdr[14 + k] = 8'(124 >> (8 * k));
      hdr[18 + k] = 8'(w >> (8 * k));
      hdr[22 + k] = 8'(h >> (8 * k));
      hdr[34 + k] = imgB[8*k +: 8];
    end
    hdr[26] = 8'd1;
    hdr[28] = 8'd24;
    checkOutput({tag, "_file_valid"}, 32'((inst == 0) ? fileValidA : fileValidB), 32'd1);
    for (int i = 0; i < 138; i++) begin
      readByte(inst, 32'(i), b);
      checkOutput($sformatf("%s_hdr%0d", tag, i), 32'(b), 32'(hdr[i]));
    end
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        px = 24'h0;
        if ((inst == 0 ? qA.size() : qB.size()) == 0) begin
          checkOutput({tag, "_scoreboard_underflow"}, 32'd0, 32'd1);
        end else begin
          px = (inst == 0) ? qA.pop_front() : qB.pop_front();
        end
        base = 138 + r * int'(rowB) + 3 * c;
        readByte(inst, 32'(base), b);
        checkOutput($sformatf("%s_px%0d_%0d_B", tag, r, c), 32'(b), 32'(px[7:0]));
        readByte(inst, 32'(base + 1), b);
        checkOutput($sformatf("%s_px%0d_%0d_G", tag, r, c), 32'(b), 32'(px[15:8]));
        readByte(inst, 32'(base + 2), b);
        checkOutput($sformatf("%s_px%0d_%0d_R", tag, r, c), 32'(b), 32'(px[23:16]));
      end
      for (int p = 3 * w; p < int'(rowB); p++) begin
        readByte(inst, 32'(138 + r * int'(rowB) + p), b);
        checkOutput($sformatf("%s_pad%0d_%0d", tag, r, p), 32'(b), 32'd0);
      end
    end
    checkOutput({tag, "_scoreboard_left"}, 32'((inst == 0) ? qA.size() : qB.size()), 32'd0);
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, "_ready"}, 32'(ifA.ready), 32'd0);
    checkOutput({tag, "_done"}, 32'(doneA), 32'd0);
    checkOutput({tag, "_pixcnt"}, pixCntA, 32'd0);
    checkOutput({tag, "_err"}, 32'(errA), 32'd0);
    checkOutput({tag, "_file"}, 32'(fileValidA), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    ifA.valid = 1'b1;
    ifA.data  = 'x;
    ifB.valid = 1'b0;
    ifB.data  = 24'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetA("rstA");
    checkOutput("rstB_ready", 32'(ifB.ready), 32'd0);
    checkOutput("rstB_pixcnt", pixCntB, 32'd0);

    // First frames: A streams index data at full rate, B sees random stalls
    ifA.data = 24'd0;
    @(negedge clk);
    rst_n = 1'b1;
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          applyStimulus(0, 24'(i));
          if (i == 0) tFirst = $time;
          if (i == 31) tLast = $time;
          checkOutput($sformatf("A_pixcnt%0d", i), pixCntA, 32'(i + 1));
          checkOutput($sformatf("A_done%0d", i), 32'(doneA), 32'(i == 31));
          checkOutput($sformatf("A_ready%0d", i), 32'(ifA.ready), 32'(i != 31));
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          applyStimulus(1, 24'($urandom));
          if (i == 0) monB = 1'b1;
          checkOutput($sformatf("B_pixcnt%0d", i), pixCntB, 32'(i + 1));
        end
      end
    join
    monB = 1'b0;
    checkOutput("A_throughput_cycles", 32'((tLast - tFirst) / 10), 32'd31);
    checkOutput("B_done", 32'(doneB), 32'd1);
    checkOutput("B_max_stall_le3", 32'(maxRunB <= 3), 32'd1);
    checkOutput("B_stalls_seen", 32'(stallB > 0), 32'd1);
    checkOutput("A_err_clean", 32'(errA), 32'd0);
    checkOutput("B_err_clean", 32'(errB), 32'd0);
    ifB.valid = 1'b0;

    // Valid held after done: nothing more is accepted and nothing is flagged
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("post_done_ready%0d", i), 32'(ifA.ready), 32'd0);
      checkOutput($sformatf("post_done_pixcnt%0d", i), pixCntA, 32'd32);
      checkOutput($sformatf("post_done_err%0d", i), 32'(errA), 32'd0);
      checkOutput($sformatf("post_done_done%0d", i), 32'(doneA), 32'd1);
    end

    checkFile(0, 8, 4, "A");
    checkFile(1, 5, 4, "B");

    // Reset in the middle of a frame, then a complete fresh frame
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    ifA.data = 24'hA5A5A5;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) applyStimulus(0, 24'(i) ^ 24'hA5A5A5);
    checkOutput("mid_pixcnt17", pixCntA, 32'd17);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetA("midrst");
    qA.delete();
    repeat (2) @(posedge clk);
    ifA.data = 24'h000000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) applyStimulus(0, 24'(i * 24'h010203));
    checkOutput("rerun_done", 32'(doneA), 32'd1);
    checkOutput("rerun_pixcnt", pixCntA, 32'd32);
    checkOutput("rerun_err", 32'(errA), 32'd0);
    checkFile(0, 8, 4, "A2");

    // Data changed while stalled in the first cycle after reset
    @(negedge clk);
    rst_n = 1'b0;
    ifA.valid = 1'b1;
    ifA.data  = 24'h123456;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("prot_data_before", 32'(errA), 32'd0);
    ifA.data = 24'h654321;
    @(posedge clk);
    #1;
    checkOutput("prot_data_flag", 32'(errA), 32'd1);
    ifA.valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("prot_data_sticky", 32'(errA), 32'd1);

    // Valid dropped while stalled
    @(negedge clk);
    rst_n = 1'b0;
    ifA.valid = 1'b1;
    ifA.data  = 24'h111111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("prot_drop_before", 32'(errA), 32'd0);
    ifA.valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("prot_drop_flag", 32'(errA), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("prot_drop_sticky", 32'(errA), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
